// File: rtl/spmv_mem_if.sv
// rtl/spmv_mem_if.sv - PE memory request/response channel between initiator and responder
interface spmv_mem_if;
  logic        req_mem_ld;
  logic        req_mem_st;
  logic [47:0] req_mem_addr;
  logic [63:0] req_mem_d_or_tag;
  logic        req_mem_stall;
  logic        rsp_mem_push;
  logic [2:0]  rsp_mem_tag;
  logic [63:0] rsp_mem_q;
  logic        rsp_mem_stall;

  modport master (
    output req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, rsp_mem_stall,
    input  req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
  );

  modport slave (
    input  req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, rsp_mem_stall,
    output req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
  );
endinterface

// File: rtl/spmv_mem_responder.sv
// rtl/spmv_mem_responder.sv - fixed-latency memory endpoint for the PE load/store interface
module spmv_mem_responder #(
  parameter int ADDR_WORDS_LOG2 = 12,
  parameter int LATENCY         = 4,
  parameter int RSP_DEPTH       = 16,
  parameter int SKID            = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  spmv_mem_if.slave                  mem_if,
  input  logic                       host_wr_en_i,
  input  logic [ADDR_WORDS_LOG2-1:0] host_wr_addr_i,
  input  logic [63:0]                host_wr_data_i,
  output logic [31:0]                ld_count_o,
  output logic [31:0]                st_count_o,
  output logic                       err_both_o,
  output logic                       err_overflow_o
);
  localparam int STAGES = LATENCY - 1;
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORDS  = 1 << ADDR_WORDS_LOG2;

  logic [63:0]                mem_q [WORDS];
  logic [ADDR_WORDS_LOG2-1:0] req_idx;
  logic                       st_req, ld_ok, ld_enq, both_hit, ovf_hit;

  logic [STAGES-1:0] pipe_v_q, pipe_v_d;
  logic [2:0]        pipe_tag_q  [STAGES];
  logic [63:0]       pipe_data_q [STAGES];

  logic [2:0]       fifo_tag_q  [RSP_DEPTH];
  logic [63:0]      fifo_data_q [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             fifo_wr, fifo_rd, rsp_push;

  logic [CNT_W-1:0] outstanding, outstanding_d;
  logic             req_stall_q;
  logic [31:0]      ld_count_q, st_count_q;
  logic             err_both_q, err_overflow_q;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_if.req_mem_addr[47:ADDR_WORDS_LOG2+3], mem_if.req_mem_addr[2:0]};

  assign req_idx  = mem_if.req_mem_addr[ADDR_WORDS_LOG2+2:3];
  assign st_req   = mem_if.req_mem_st;
  assign both_hit = mem_if.req_mem_ld && mem_if.req_mem_st;
  assign ld_ok    = mem_if.req_mem_ld && !mem_if.req_mem_st;
  assign ovf_hit  = ld_ok && (outstanding == CNT_W'(RSP_DEPTH));
  assign ld_enq   = ld_ok && !ovf_hit;

  assign fifo_wr  = pipe_v_q[STAGES-1];
  assign rsp_push = (fifo_cnt_q != '0) && !mem_if.rsp_mem_stall;
  assign fifo_rd  = rsp_push;

  always_comb begin
    pipe_v_d    = '0;
    pipe_v_d[0] = ld_enq;
    for (int i = 1; i < STAGES; i++) pipe_v_d[i] = pipe_v_q[i-1];
    fifo_cnt_d    = fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
    outstanding   = fifo_cnt_q;
    outstanding_d = fifo_cnt_d;
    for (int i = 0; i < STAGES; i++) begin
      outstanding   = outstanding + CNT_W'(pipe_v_q[i]);
      outstanding_d = outstanding_d + CNT_W'(pipe_v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v_q       <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
      req_stall_q    <= 1'b0;
      ld_count_q     <= '0;
      st_count_q     <= '0;
      err_both_q     <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      pipe_v_q    <= pipe_v_d;
      fifo_cnt_q  <= fifo_cnt_d;
      req_stall_q <= (outstanding_d >= CNT_W'(RSP_DEPTH - SKID));
      if (fifo_wr)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_rd)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (st_req)   st_count_q <= st_count_q + 32'd1;
      if (ld_ok)    ld_count_q <= ld_count_q + 32'd1;
      if (both_hit) err_both_q <= 1'b1;
      if (ovf_hit)  err_overflow_q <= 1'b1;
    end
  end

  // Datapath storage carries no reset; validity lives in the control state above.
  always_ff @(posedge clk) begin
    if (host_wr_en_i) mem_q[host_wr_addr_i] <= host_wr_data_i;
    if (st_req && !rst) mem_q[req_idx] <= mem_if.req_mem_d_or_tag;
    pipe_tag_q[0]  <= mem_if.req_mem_d_or_tag[2:0];
    pipe_data_q[0] <= mem_q[req_idx];
    for (int i = 1; i < STAGES; i++) begin
      pipe_tag_q[i]  <= pipe_tag_q[i-1];
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
    if (fifo_wr) begin
      fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[STAGES-1];
      fifo_data_q[wr_ptr_q] <= pipe_data_q[STAGES-1];
    end
  end

  assign mem_if.req_mem_stall = req_stall_q;
  assign mem_if.rsp_mem_push  = rsp_push;
  assign mem_if.rsp_mem_tag   = fifo_tag_q[rd_ptr_q];
  assign mem_if.rsp_mem_q     = fifo_data_q[rd_ptr_q];
  assign ld_count_o           = ld_count_q;
  assign st_count_o           = st_count_q;
  assign err_both_o           = err_both_q;
  assign err_overflow_o       = err_overflow_q;
endmodule

// File: doc/spmv_mem_responder.md
Name: spmv_mem_responder

Overview:
- Memory-side endpoint of the PE memory request/response interface.
- Accepts one load or store per cycle from an spmv_pe-style initiator. Loads are answered after a fixed latency on the rsp_mem_* channel, carrying the request tag. Stores are absorbed without a response.
- Backed by an on-chip 64-bit word array, preloadable through a host write port. Used as a synthesizable memory stand-in for PE bring-up and as the per-PE port model on the MC side.

Parameters:
ADDR_WORDS_LOG2, 12, log2 of backing-array depth in 64-bit words
LATENCY, 4, cycles from load acceptance to earliest rsp_mem_push (>=2)
RSP_DEPTH, 16, response FIFO depth (power of 2, >= SKID+2)
SKID, 3, requests the initiator may still issue after sampling req_mem_stall

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_mem_ld  in  1  load request valid
req_mem_st  in  1  store request valid
req_mem_addr  in  48  byte address
req_mem_d_or_tag  in  64  store data; for loads, bits [2:0] are the tag
req_mem_stall  out  1  registered backpressure to initiator
rsp_mem_push  out  1  response valid
rsp_mem_tag  out  3  tag echoed from the load
rsp_mem_q  out  64  load data
rsp_mem_stall  in  1  initiator cannot accept a response this cycle
host_wr_en  in  1  preload write strobe
host_wr_addr  in  ADDR_WORDS_LOG2  word index
host_wr_data  in  64  preload data
ld_count  out  32  loads accepted since reset
st_count  out  32  stores accepted since reset
err_both  out  1  sticky: ld and st asserted together
err_overflow  out  1  sticky: load accepted with no response space

Behaviour:
- Word index = req_mem_addr[ADDR_WORDS_LOG2+2:3]. Low 3 bits and bits above the index are ignored (wrap-around aliasing).
- Store (st=1): array[idx] <= d_or_tag at that clock edge. No response. st_count += 1.
- Load (ld=1, st=0): array read at acceptance edge. {tag, data} enters a LATENCY-1 deep valid/tag/data shift pipeline. ld_count += 1.
- Read ordering: a load sees all stores accepted in earlier cycles.
- ld && st in the same cycle:
  - Store performed; load dropped.
  - err_both set; st_count increments, ld_count does not.
- Host write and request store to the same cycle: the request store wins.
- Pipeline exit writes into the response FIFO (first-word fall-through).
- Response channel:
  - rsp_mem_push = !fifo_empty && !rsp_mem_stall; head popped on push.
  - rsp_mem_tag/rsp_mem_q show the FIFO head and are don't-care when push=0.
  - Uncontested load accepted at edge t gives rsp_mem_push=1 in cycle t+LATENCY.
- Credit accounting:
  - outstanding = fifo occupancy + valid pipeline stages.
  - req_mem_stall <= (outstanding_next >= RSP_DEPTH - SKID), registered.
  - Requests arriving while stall=1 are still accepted (skid). Responses are never dropped while the initiator honours SKID.
- Overflow:
  - If a load is accepted while outstanding == RSP_DEPTH, set err_overflow and drop that load.
  - ld_count still increments for the dropped load.
- Same-cycle FIFO push and pop: both occur; occupancy is unchanged.
- rsp_mem_stall has no effect on request acceptance except through the credit count.
- Reset (at any time, including mid-burst):
  - Clears the pipeline, FIFO, counters and error flags.
  - req_mem_stall=0 and rsp_mem_push=0 in the cycle after the rst edge.
  - In-flight loads are discarded. Array contents are retained.
- Counters wrap at 2^32.

Test Plan:
- Preload word 5 = 0x3FF0000000000000 via host port; load addr 0x28, tag 3 at t → rsp_mem_push only at t+4, tag=3, q=0x3FF0000000000000.
- Store 0xDEADBEEF to addr 0x40, load 0x40 the next cycle → response q=0xDEADBEEF; st_count=1, ld_count=1.
- Hold rsp_mem_stall=1 and issue back-to-back loads, stopping 2 cycles after req_mem_stall rises:
  - req_mem_stall asserts once outstanding reaches 13.
  - No err_overflow.
  - After stall release, all responses arrive in issue order with correct tags.
- Drive 17 loads ignoring stall while rsp_mem_stall=1 → err_overflow=1; exactly 16 responses after release.
- ld=st=1 at addr 0x8 with data 7 → err_both=1; word 1 = 7; no response.
- Assert rst with 3 loads in flight → no rsp_mem_push afterwards; counters = 0; preloaded data is still readable.
